// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the writeback register file and its decode helper.
//   ICODE_*      : instruction codes HALT..POPQ
//   RNONE        : "no register" id, never written, reads as zero
//   RSP          : default stack-pointer register id
//   reg_id_t     : 4-bit register specifier
//   is_writable  : true when an id names a real register of an NREGS-entry file
package y86_pkg;

  typedef logic [3:0] reg_id_t;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_CMOVXX = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam reg_id_t RNONE = 4'hF;
  localparam reg_id_t RSP   = 4'h4;

  function automatic logic is_writable(input reg_id_t id, input int unsigned nregs);
    return (id != RNONE) && (32'(id) < nregs);
  endfunction

endpackage

// File: rtl/wb_dest_decode.sv
// Combinational destination decode for the writeback stage.
// Ports:
//   i_icode, i_ra, i_rb : instruction code and register specifiers
//   i_cnd               : execute condition flag (qualifies cmovXX)
//   o_dst_e             : destination for valE (RNONE if none)
//   o_dst_m             : destination for valM (RNONE if none)
module wb_dest_decode
  import y86_pkg::*;
#(
  parameter reg_id_t RSP_ID = RSP
) (
  input  logic [3:0] i_icode,
  input  logic [3:0] i_ra,
  input  logic [3:0] i_rb,
  input  logic       i_cnd,
  output logic [3:0] o_dst_e,
  output logic [3:0] o_dst_m
);

  always_comb begin
    o_dst_e = RNONE;
    o_dst_m = RNONE;
    case (i_icode)
      ICODE_CMOVXX:           o_dst_e = i_cnd ? i_rb : RNONE;
      ICODE_IRMOVQ, ICODE_OPQ: o_dst_e = i_rb;
      ICODE_MRMOVQ:           o_dst_m = i_ra;
      ICODE_CALL, ICODE_RET, ICODE_PUSHQ: o_dst_e = RSP_ID;
      ICODE_POPQ: begin
        o_dst_e = RSP_ID;
        o_dst_m = i_ra;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_regfile_multiport.sv
// Writeback register file: NREGS x XLEN registers, dual write (valE/valM) on
// a valid-qualified commit, two combinational read ports, a debug read port
// and a retired-instruction counter.
// Build option: define WB_BYPASS_EN to forward the retiring valM/valE onto
// val_a/val_b in the commit cycle (dbg_data never forwards).
// Ports:
//   clock, reset_n          : rising-edge clock, synchronous active-low reset
//   wb_valid                : commit strobe
//   icode, ra, rb, cnd      : retiring instruction fields
//   vale, valm              : ALU result / memory data to write
//   src_a, src_b -> val_a, val_b : read ports (RNONE / out of range read 0)
//   dbg_addr -> dbg_data    : debug read port
//   retired                 : committed instruction count (wraps)
module wb_regfile_multiport
  import y86_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NREGS  = 15,
  parameter reg_id_t     RSP_ID = RSP,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wb_valid,
  input  logic [3:0]       icode,
  input  logic [3:0]       ra,
  input  logic [3:0]       rb,
  input  logic             cnd,
  input  logic [XLEN-1:0]  vale,
  input  logic [XLEN-1:0]  valm,
  input  logic [3:0]       src_a,
  input  logic [3:0]       src_b,
  output logic [XLEN-1:0]  val_a,
  output logic [XLEN-1:0]  val_b,
  input  logic [3:0]       dbg_addr,
  output logic [XLEN-1:0]  dbg_data,
  output logic [CNT_W-1:0] retired
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [CNT_W-1:0] r_retired;

  logic [3:0] w_dst_e;
  logic [3:0] w_dst_m;
  logic       w_we_e;
  logic       w_we_m;
  logic [XLEN-1:0] w_arr_a;
  logic [XLEN-1:0] w_arr_b;

  wb_dest_decode #(
    .RSP_ID(RSP_ID)
  ) u_dest_decode (
    .i_icode (icode),
    .i_ra    (ra),
    .i_rb    (rb),
    .i_cnd   (cnd),
    .o_dst_e (w_dst_e),
    .o_dst_m (w_dst_m)
  );

  assign w_we_e = is_writable(w_dst_e, NREGS);
  assign w_we_m = is_writable(w_dst_m, NREGS);

  // Port M is written after port E so that on dstE==dstM the later
  // non-blocking update (valM) is the one that lands.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_regs    <= '{default: '0};
      r_retired <= '0;
    end else if (wb_valid) begin
      if (w_we_e) r_regs[w_dst_e] <= vale;
      if (w_we_m) r_regs[w_dst_m] <= valm;
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_arr_a  = is_writable(src_a, NREGS)    ? r_regs[src_a]    : '0;
    w_arr_b  = is_writable(src_b, NREGS)    ? r_regs[src_b]    : '0;
    dbg_data = is_writable(dbg_addr, NREGS) ? r_regs[dbg_addr] : '0;
  end

`ifdef WB_BYPASS_EN
  // Forward the value being committed this edge; M has priority to match
  // the write-port precedence above.
  always_comb begin
    val_a = w_arr_a;
    val_b = w_arr_b;
    if (wb_valid && w_we_e && (src_a == w_dst_e)) val_a = vale;
    if (wb_valid && w_we_m && (src_a == w_dst_m)) val_a = valm;
    if (wb_valid && w_we_e && (src_b == w_dst_e)) val_b = vale;
    if (wb_valid && w_we_m && (src_b == w_dst_m)) val_b = valm;
  end
`else
  always_comb begin
    val_a = w_arr_a;
    val_b = w_arr_b;
  end
`endif

  assign retired = r_retired;

endmodule
